spectro_pin_bridge: RTL and testbench

SPECTRO_PIN_BRIDGE -- requirements
Module: spectro_pin_bridge

---
 rtl/spectro_pin_bridge_pkg.sv | 19 +
 rtl/spectro_byte_serializer.sv | 60 ++++++
 rtl/spectro_pin_bridge.sv | 96 +++++++++
 tb/tb_spectro_pin_bridge.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectro_pin_bridge_pkg.sv
// Shared widths, defaults and state encodings for the spectrometer pin bridge.
package spectro_pin_bridge_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PIN_W         = 8;
    localparam int IN_BYTES_DEF  = 4;
    localparam int OUT_BYTES_DEF = 2;
    localparam int IN_IDX_W      = idx_w(IN_BYTES_DEF);
    localparam int OUT_IDX_W     = idx_w(OUT_BYTES_DEF);

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/spectro_byte_serializer.sv
// Outbound path: splits a result word into pin bytes, least significant first.
module spectro_byte_serializer
    import spectro_pin_bridge_pkg::*;
#(
    parameter int OUT_BYTES = OUT_BYTES_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       word_in_valid,
    output logic                       word_in_ready,
    input  logic [PIN_W*OUT_BYTES-1:0] word_in_data,
    input  logic                       pin_out_ready,
    output logic                       pin_out_valid,
    output logic [PIN_W-1:0]           pin_out_data
);

    localparam int OW = PIN_W * OUT_BYTES;
    localparam int IW = idx_w(OUT_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(OUT_BYTES - 1);

    ser_state_t    state;
    logic [IW-1:0] idx;
    logic [OW-1:0] shreg;
    logic          on_last;
    logic          load;

    assign on_last       = (state == SER_SEND) && (idx == LAST_IDX);
    // Reloading while the last byte leaves keeps the byte stream gapless.
    assign word_in_ready = enable && ((state == SER_IDLE) || (on_last && pin_out_ready));
    assign load          = word_in_valid && word_in_ready;
    assign pin_out_data  = shreg[PIN_W-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= SER_IDLE;
            idx           <= '0;
            shreg         <= '0;
            pin_out_valid <= 1'b0;
        end else begin
            if (load) begin
                state         <= SER_SEND;
                idx           <= '0;
                shreg         <= word_in_data;
                pin_out_valid <= 1'b1;
            end else if ((state == SER_SEND) && pin_out_ready) begin
                if (on_last) begin
                    state         <= SER_IDLE;
                    idx           <= '0;
                    shreg         <= '0;
                    pin_out_valid <= 1'b0;
                end else begin
                    idx   <= idx + 1'b1;
                    shreg <= shreg >> PIN_W;
                end
            end
        end
    end

endmodule

// File: rtl/spectro_pin_bridge.sv
// Byte-pin to word bridge: inline deserializer inbound, byte serializer outbound.
module spectro_pin_bridge
    import spectro_pin_bridge_pkg::*;
#(
    parameter int IN_BYTES  = IN_BYTES_DEF,
    parameter int OUT_BYTES = OUT_BYTES_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       pin_in_ready,
    input  logic                       pin_in_valid,
    input  logic [PIN_W-1:0]           pin_in_data,
    input  logic                       pin_in_last,
    output logic                       word_out_valid,
    input  logic                       word_out_ready,
    output logic [PIN_W*IN_BYTES-1:0]  word_out_data,
    output logic                       word_out_last,
    input  logic                       word_in_valid,
    output logic                       word_in_ready,
    input  logic [PIN_W*OUT_BYTES-1:0] word_in_data,
    input  logic                       pin_out_ready,
    output logic                       pin_out_valid,
    output logic [PIN_W-1:0]           pin_out_data
);

    localparam int INW = PIN_W * IN_BYTES;
    localparam int IW  = idx_w(IN_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(IN_BYTES - 1);

    logic           run_en;
    logic [IW-1:0]  in_idx;
    logic [INW-1:0] in_acc;
    logic [INW-1:0] in_merged;
    logic           in_fire;
    logic           word_fire;
    logic           in_close;

    assign pin_in_ready = run_en && (!word_out_valid || word_out_ready);
    assign in_fire      = pin_in_valid && pin_in_ready;
    assign word_fire    = word_out_valid && word_out_ready;
    assign in_close     = pin_in_last || (in_idx == LAST_IDX);

    // Accumulator is cleared on every close, so unfilled upper bytes are zero.
    always_comb begin
        in_merged = in_acc;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (in_idx == IW'(k)) begin
                in_merged[k*PIN_W +: PIN_W] = pin_in_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_en         <= 1'b0;
            in_idx         <= '0;
            in_acc         <= '0;
            word_out_valid <= 1'b0;
            word_out_last  <= 1'b0;
            word_out_data  <= '0;
        end else begin
            run_en <= 1'b1;
            if (in_fire && in_close) begin
                in_idx         <= '0;
                in_acc         <= '0;
                word_out_data  <= in_merged;
                word_out_valid <= 1'b1;
                word_out_last  <= pin_in_last;
            end else begin
                if (in_fire) begin
                    in_idx <= in_idx + 1'b1;
                    in_acc <= in_merged;
                end
                if (word_fire) begin
                    word_out_valid <= 1'b0;
                    word_out_last  <= 1'b0;
                end
            end
        end
    end

    spectro_byte_serializer #(
        .OUT_BYTES(OUT_BYTES)
    ) u_ser (
        .clock        (clock),
        .reset        (reset),
        .enable       (run_en),
        .word_in_valid(word_in_valid),
        .word_in_ready(word_in_ready),
        .word_in_data (word_in_data),
        .pin_out_ready(pin_out_ready),
        .pin_out_valid(pin_out_valid),
        .pin_out_data (pin_out_data)
    );

endmodule

// File: tb/tb_spectro_pin_bridge.sv
// Directed bench for spectro_pin_bridge with hand-computed expectations.
module tb_spectro_pin_bridge;

    logic        clock;
    logic        reset;
    logic        pin_in_ready;
    logic        pin_in_valid;
    logic [7:0]  pin_in_data;
    logic        pin_in_last;
    logic        word_out_valid;
    logic        word_out_ready;
    logic [31:0] word_out_data;
    logic        word_out_last;
    logic        word_in_valid;
    logic        word_in_ready;
    logic [15:0] word_in_data;
    logic        pin_out_ready;
    logic        pin_out_valid;
    logic [7:0]  pin_out_data;

    int checks = 0;
    int errors = 0;

    spectro_pin_bridge dut (
        .clock         (clock),
        .reset         (reset),
        .pin_in_ready  (pin_in_ready),
        .pin_in_valid  (pin_in_valid),
        .pin_in_data   (pin_in_data),
        .pin_in_last   (pin_in_last),
        .word_out_valid(word_out_valid),
        .word_out_ready(word_out_ready),
        .word_out_data (word_out_data),
        .word_out_last (word_out_last),
        .word_in_valid (word_in_valid),
        .word_in_ready (word_in_ready),
        .word_in_data  (word_in_data),
        .pin_out_ready (pin_out_ready),
        .pin_out_valid (pin_out_valid),
        .pin_out_data  (pin_out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic drive_in(input logic [7:0] b, input logic last);
        pin_in_valid = 1'b1;
        pin_in_data  = b;
        pin_in_last  = last;
    endtask

    function automatic logic [15:0] golden(input int i);
        logic [31:0] t;
        t = i * 40503 + 257;
        return t[15:0];
    endfunction

    logic [7:0] first_b;
    logic [7:0] second_b;
    logic [7:0] lo;
    int k;
    int nbytes;
    int gaps;
    int started;
    int inj;
    int nwords;

    initial begin
        reset = 1'b1;
        pin_in_valid = 1'b0;
        pin_in_data = 8'h00;
        pin_in_last = 1'b0;
        word_out_ready = 1'b0;
        word_in_valid = 1'b0;
        word_in_data = 16'h0000;
        pin_out_ready = 1'b0;

        // reset state
        repeat (3) cyc();
        #1;
        chk("rst_pin_in_ready", 32'(pin_in_ready), 0);
        chk("rst_word_in_ready", 32'(word_in_ready), 0);
        chk("rst_word_out_valid", 32'(word_out_valid), 0);
        chk("rst_word_out_last", 32'(word_out_last), 0);
        chk("rst_word_out_data", word_out_data, 0);
        chk("rst_pin_out_valid", 32'(pin_out_valid), 0);
        reset = 1'b0;
        #1;
        chk("rel_pin_in_ready_pre", 32'(pin_in_ready), 0);
        chk("rel_word_in_ready_pre", 32'(word_in_ready), 0);
        cyc();
        #1;
        chk("rel_pin_in_ready", 32'(pin_in_ready), 1);
        chk("rel_word_in_ready", 32'(word_in_ready), 1);

        // four words 04,00,00,00 streamed with word_out_ready high
        word_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            drive_in((i % 4 == 0) ? 8'h04 : 8'h00, 1'b0);
            #1;
            chk("s22_in_ready", 32'(pin_in_ready), 1);
            if (i % 4 == 0 && i > 0) begin
                chk("s22_valid", 32'(word_out_valid), 1);
                chk("s22_data", word_out_data, 32'h0000_0004);
                chk("s22_last", 32'(word_out_last), 0);
            end else begin
                chk("s22_idle", 32'(word_out_valid), 0);
            end
        end
        cyc();
        pin_in_valid = 1'b0;
        #1;
        chk("s22_valid4", 32'(word_out_valid), 1);
        chk("s22_data4", word_out_data, 32'h0000_0004);
        cyc();
        #1;
        chk("s22_drained", 32'(word_out_valid), 0);

        // stall on word_out_ready, then release
        word_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            drive_in((i == 0) ? 8'h04 : 8'h00, 1'b0);
            #1;
            chk("s23_in_ready", 32'(pin_in_ready), 1);
        end
        cyc();
        drive_in(8'h04, 1'b0);
        #1;
        chk("s23_stall_ready", 32'(pin_in_ready), 0);
        chk("s23_stall_valid", 32'(word_out_valid), 1);
        chk("s23_stall_data", word_out_data, 32'h0000_0004);
        cyc();
        #1;
        chk("s23_stall_ready2", 32'(pin_in_ready), 0);
        chk("s23_stall_data2", word_out_data, 32'h0000_0004);
        cyc();
        word_out_ready = 1'b1;
        #1;
        chk("s23_release_ready", 32'(pin_in_ready), 1);
        cyc();
        drive_in(8'h00, 1'b0);
        #1;
        chk("s23_taken", 32'(word_out_valid), 0);
        cyc();
        drive_in(8'h00, 1'b0);
        cyc();
        drive_in(8'h00, 1'b0);
        cyc();
        pin_in_valid = 1'b0;
        #1;
        chk("s23_next_valid", 32'(word_out_valid), 1);
        chk("s23_next_data", word_out_data, 32'h0000_0004);
        chk("s23_next_last", 32'(word_out_last), 0);

        // short frame closed by pin_in_last, then index restarts at 0
        cyc();
        drive_in(8'h11, 1'b0);
        cyc();
        drive_in(8'h22, 1'b1);
        cyc();
        pin_in_valid = 1'b0;
        pin_in_last = 1'b0;
        #1;
        chk("s26_valid", 32'(word_out_valid), 1);
        chk("s26_data", word_out_data, 32'h0000_2211);
        chk("s26_last", 32'(word_out_last), 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            drive_in(8'(i + 1), 1'b0);
        end
        cyc();
        pin_in_valid = 1'b0;
        #1;
        chk("s26_next_data", word_out_data, 32'h0403_0201);
        chk("s26_next_last", 32'(word_out_last), 0);

        // single outbound word, receiver always ready
        pin_out_ready = 1'b1;
        cyc();
        word_in_valid = 1'b1;
        word_in_data = 16'hABCD;
        #1;
        chk("s24_word_in_ready", 32'(word_in_ready), 1);
        chk("s24_pre_valid", 32'(pin_out_valid), 0);
        cyc();
        word_in_valid = 1'b0;
        #1;
        chk("s24_b0_valid", 32'(pin_out_valid), 1);
        chk("s24_b0_data", 32'(pin_out_data), 32'hCD);
        first_b = pin_out_data;
        cyc();
        #1;
        chk("s24_b1_valid", 32'(pin_out_valid), 1);
        chk("s24_b1_data", 32'(pin_out_data), 32'hAB);
        second_b = pin_out_data;
        cyc();
        #1;
        chk("s24_done", 32'(pin_out_valid), 0);
        chk("s24_reassembled", 32'({second_b, first_b}), 32'hABCD);

        // outbound backpressure holds the byte stable
        pin_out_ready = 1'b0;
        cyc();
        word_in_valid = 1'b1;
        word_in_data = 16'h1234;
        cyc();
        word_in_valid = 1'b0;
        #1;
        chk("bp_b0_data", 32'(pin_out_data), 32'h34);
        chk("bp_busy_ready", 32'(word_in_ready), 0);
        cyc();
        #1;
        chk("bp_hold_valid", 32'(pin_out_valid), 1);
        chk("bp_hold_data", 32'(pin_out_data), 32'h34);
        cyc();
        pin_out_ready = 1'b1;
        #1;
        chk("bp_b0_ready", 32'(word_in_ready), 0);
        cyc();
        #1;
        chk("bp_b1_data", 32'(pin_out_data), 32'h12);
        chk("bp_b1_ready", 32'(word_in_ready), 1);
        cyc();
        #1;
        chk("bp_done", 32'(pin_out_valid), 0);

        // 1024 words back-to-back with concurrent inbound traffic
        k = 0;
        nbytes = 0;
        gaps = 0;
        started = 0;
        inj = 0;
        nwords = 0;
        lo = 8'h00;
        for (int c = 0; c < 5000 && nbytes < 2048; c++) begin
            cyc();
            word_in_valid = (k < 1024);
            word_in_data = golden(k);
            pin_in_valid = (inj < 8);
            pin_in_data = 8'(8'h10 + inj);
            pin_in_last = 1'b0;
            #1;
            if (pin_out_valid) begin
                started = 1;
                if (nbytes % 2 == 1) begin
                    chk("s25_pair", 32'({pin_out_data, lo}), 32'(golden(nbytes / 2)));
                end else begin
                    lo = pin_out_data;
                end
                nbytes++;
            end else if (started != 0) begin
                gaps++;
            end
            if (word_out_valid) begin
                chk("s15_word", word_out_data, 32'h1312_1110 + nwords * 32'h0404_0404);
                nwords++;
            end
            if (word_in_valid && word_in_ready) k++;
            if (pin_in_valid && pin_in_ready) inj++;
        end
        chk("s25_bytes", nbytes, 2048);
        chk("s25_gaps", gaps, 0);
        chk("s25_words_taken", k, 1024);
        chk("s15_words_seen", nwords, 2);
        cyc();
        word_in_valid = 1'b0;
        pin_in_valid = 1'b0;
        #1;
        chk("s25_no_extra", 32'(pin_out_valid), 0);

        // reset in the middle of both paths
        pin_out_ready = 1'b0;
        cyc();
        drive_in(8'hAA, 1'b0);
        cyc();
        drive_in(8'hBB, 1'b0);
        cyc();
        pin_in_valid = 1'b0;
        word_in_valid = 1'b1;
        word_in_data = 16'h5566;
        cyc();
        word_in_valid = 1'b0;
        #1;
        chk("s27_pre_out_data", 32'(pin_out_data), 32'h66);
        reset = 1'b1;
        #1;
        chk("s27_rst_pin_out_valid", 32'(pin_out_valid), 0);
        chk("s27_rst_word_out_valid", 32'(word_out_valid), 0);
        chk("s27_rst_pin_in_ready", 32'(pin_in_ready), 0);
        chk("s27_rst_word_in_ready", 32'(word_in_ready), 0);
        chk("s27_rst_pin_out_data", 32'(pin_out_data), 0);
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        #1;
        chk("s27_rel_ready", 32'(pin_in_ready), 1);
        chk("s27_rel_out_valid", 32'(pin_out_valid), 0);
        cyc();
        drive_in(8'hA1, 1'b0);
        cyc();
        drive_in(8'hB2, 1'b0);
        cyc();
        drive_in(8'hC3, 1'b0);
        cyc();
        drive_in(8'hD4, 1'b0);
        cyc();
        pin_in_valid = 1'b0;
        #1;
        chk("s27_fresh_valid", 32'(word_out_valid), 1);
        chk("s27_fresh_data", word_out_data, 32'hD4C3_B2A1);
        pin_out_ready = 1'b1;
        word_in_valid = 1'b1;
        word_in_data = 16'h7788;
        cyc();
        word_in_valid = 1'b0;
        #1;
        chk("s27_fresh_b0", 32'(pin_out_data), 32'h88);
        cyc();
        #1;
        chk("s27_fresh_b1", 32'(pin_out_data), 32'h77);
        cyc();
        #1;
        chk("s27_fresh_done", 32'(pin_out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
